instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Packs opcode/source/destination fields into the 8-bit instruction word consumed by instruction_decoder.
//  Word format: instr[7:4]=opcode, instr[3:2]=source reg, instr[1:0]=destination reg.
//  Fields are accepted through a valid/ready input port and buffered in a DEPTH-entry FIFO.
//  Words leave through a valid/ready output port toward the decode stage.
//  Opcode 4'hF is reserved: such a request is consumed, dropped and flagged.
// PARAMETERS
//  DEPTH   4  FIFO entries; power of 2, >= 2
//  CNT_W   8  width of encoded_count
// PORTS
//  clk                     in   1               single clock, rising edge
//  rst                     in   1               asynchronous, active-high reset
//  in_valid                in   1               field set valid
//  in_ready                out  1               encoder can accept a field set
//  in_op_code              in   4               opcode field
//  in_source_register      in   2               source register field
//  in_destination_register in   2               destination register field
//  out_valid               out  1               out_instruction valid
//  out_ready               in   1               consumer accepts out_instruction
//  out_instruction         out  8               encoded instruction word
//  fifo_count              out  $clog2(DEPTH)+1 occupied entries, 0..DEPTH
//  illegal_flag            out  1               sticky: reserved opcode seen
//  clr_err                 in   1               synchronous clear of illegal_flag
//  encoded_count           out  CNT_W           words enqueued since reset, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): pointers = 0, fifo_count = 0, out_valid = 0.
//   Also at reset: out_instruction = 8'h00, illegal_flag = 0, encoded_count = 0; FIFO contents discarded.
//  in_ready = (fifo_count < DEPTH), registered state only; it never depends on out_ready.
//  Accept = in_valid & in_ready at a rising edge.
//   Legal opcode (!= 4'hF): word is written at wr_ptr; wr_ptr increments mod DEPTH.
//   Reserved opcode (4'hF): nothing is written and no count changes; illegal_flag <= 1.
//  Pop = out_valid & out_ready at a rising edge: rd_ptr increments mod DEPTH.
//  out_valid = (fifo_count != 0).
//   out_instruction = mem[rd_ptr] while out_valid, else 8'h00.
//   out_instruction stays stable while out_valid & !out_ready.
//  Latency: a word accepted at edge N (FIFO empty) shows out_valid = 1 after edge N; popped at N+1 at the earliest.
//  Count update: legal accept only -> +1; pop only -> -1; legal accept and pop in the same cycle -> unchanged.
//  Full (count = DEPTH): in_ready = 0, so no accept, even when a pop happens in the same cycle; in_ready rises the cycle after the pop.
//  Empty: no pop is possible. A simultaneous accept proceeds as a normal push.
//  Pointer wrap: DEPTH-1 -> 0, with no gap or duplicate word.
//  Word order: FIFO order is strictly preserved.
//  encoded_count: +1 per legal accept; holds at 2^CNT_W-1; never wraps.
//  illegal_flag:
//   - clr_err and a reserved accept in the same cycle -> flag = 1 (set wins).
//   - Otherwise clr_err -> 0.
//  Reset mid-transfer: all state returns to reset values immediately; no partial word is emitted.
// TESTING
//  1. After reset release, push op=3, src=1, dst=2 with out_ready=0 -> next cycle out_instruction=8'h36, out_valid=1, fifo_count=1.
//  2. Hold out_ready=0 and push 4 legal words -> fifo_count=4, in_ready=0; a 5th in_valid is not taken and the count stays 4.
//  3. Full FIFO, then raise out_ready for 4 cycles -> the 4 words emerge in push order; out_valid=0 and out_instruction=8'h00 afterwards.
//  4. Push op=F, src=0, dst=1 -> in_ready stays 1, fifo_count unchanged, illegal_flag=1; clr_err for 1 cycle -> 0.
//  5. Continuous push and pop for 10 words with DEPTH=4 -> pointers wrap, count stays at 1, encoded_count=10, no data loss.
//  6. Assert rst with 3 entries buffered -> out_valid=0, fifo_count=0 and encoded_count=0 with no clock edge.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs {opcode,src,dst} into 8-bit words through a DEPTH-entry FIFO; 1-cycle in->out latency.
// in_ready reflects registered occupancy only; reserved opcode 4'hF is consumed, dropped and flagged.
module instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op_code,
  input  logic [1:0]               in_source_register,
  input  logic [1:0]               in_destination_register,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_instruction,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     illegal_flag,
  input  logic                     clr_err,
  output logic [CNT_W-1:0]         encoded_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
  localparam logic [3:0]    LP_RSVD = 4'hF;

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_illegal;
  logic [CNT_W-1:0] r_enc_cnt;

  logic             w_accept;
  logic             w_push;
  logic             w_rsvd;
  logic             w_pop;
  logic [7:0]       w_word;

  assign in_ready   = (r_count < LP_FULL);
  assign out_valid  = (r_count != '0);
  assign w_accept   = in_valid & in_ready;
  assign w_rsvd     = w_accept & (in_op_code == LP_RSVD);
  assign w_push     = w_accept & (in_op_code != LP_RSVD);
  assign w_pop      = out_valid & out_ready;
  assign w_word     = {in_op_code, in_source_register, in_destination_register};

  assign out_instruction = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_count      = r_count;
  assign illegal_flag    = r_illegal;
  assign encoded_count   = r_enc_cnt;

  // Storage needs no reset: stale entries are never visible because the output is gated by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
      r_enc_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_rsvd) begin
        r_illegal <= 1'b1;
      end else if (clr_err) begin
        r_illegal <= 1'b0;
      end
      if (w_push && (r_enc_cnt != '1)) begin
        r_enc_cnt <= r_enc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: inputs change 1ns after the rising edge, outputs checked there.
module tb_instruction_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op_code;
  logic [1:0] in_source_register;
  logic [1:0] in_destination_register;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instruction;
  logic [2:0] fifo_count;
  logic       illegal_flag;
  logic       clr_err;
  logic [7:0] encoded_count;

  int n_chk = 0;
  int n_err = 0;

  instruction_encoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_op_code              (in_op_code),
    .in_source_register      (in_source_register),
    .in_destination_register (in_destination_register),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_instruction         (out_instruction),
    .fifo_count              (fifo_count),
    .illegal_flag            (illegal_flag),
    .clr_err                 (clr_err),
    .encoded_count           (encoded_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] op, input logic [1:0] src, input logic [1:0] dst);
    in_valid                = vld;
    in_op_code              = op;
    in_source_register      = src;
    in_destination_register = dst;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [7:0] exp_word;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    clr_err = 1'b0;
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_instr", out_instruction, 8'h00);
    chk("rst_flag", illegal_flag, 0);
    chk("rst_enc", encoded_count, 0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);

    // 1: single push, first-word latency
    drive(1'b1, 4'h3, 2'd1, 2'd2);
    step();
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    chk("t1_instr", out_instruction, 8'h36);
    chk("t1_valid", out_valid, 1);
    chk("t1_count", fifo_count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_pop_count", fifo_count, 0);
    chk("t1_pop_instr", out_instruction, 8'h00);

    // 2: fill to DEPTH, extra request refused
    drive(1'b1, 4'h1, 2'd0, 2'd3); step();
    drive(1'b1, 4'h2, 2'd2, 2'd1); step();
    drive(1'b1, 4'hA, 2'd3, 2'd3); step();
    drive(1'b1, 4'hE, 2'd1, 2'd0); step();
    chk("t2_count4", fifo_count, 4);
    chk("t2_in_ready", in_ready, 0);
    drive(1'b1, 4'h5, 2'd0, 2'd0);
    step();
    chk("t2_still4", fifo_count, 4);
    chk("t2_head_stable", out_instruction, 8'h13);

    // 3: drain in order; pop while full does not admit the pending word
    out_ready = 1'b1;
    step();
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    chk("t3_count3", fifo_count, 3);
    chk("t3_w1", out_instruction, 8'h29);
    step();
    chk("t3_w2", out_instruction, 8'hAF);
    step();
    chk("t3_w3", out_instruction, 8'hE4);
    step();
    out_ready = 1'b0;
    chk("t3_empty_valid", out_valid, 0);
    chk("t3_empty_instr", out_instruction, 8'h00);
    chk("t3_enc", encoded_count, 5);

    // 4: reserved opcode
    drive(1'b1, 4'hF, 2'd0, 2'd1);
    chk("t4_in_ready", in_ready, 1);
    step();
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    chk("t4_flag", illegal_flag, 1);
    chk("t4_count", fifo_count, 0);
    chk("t4_enc", encoded_count, 5);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_clr", illegal_flag, 0);
    clr_err = 1'b1;
    drive(1'b1, 4'hF, 2'd2, 2'd2);
    step();
    clr_err = 1'b0;
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    chk("t4_set_wins", illegal_flag, 1);

    // 5: streaming push/pop across pointer wrap
    pulse_reset();
    chk("t5_rst_flag", illegal_flag, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), 2'(i), 2'(i + 1));
      step();
      exp_word = {4'(i), 2'(i), 2'(i + 1)};
      chk($sformatf("t5_word%0d", i), out_instruction, exp_word);
      chk($sformatf("t5_count%0d", i), fifo_count, 1);
    end
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    step();
    out_ready = 1'b0;
    chk("t5_enc", encoded_count, 10);
    chk("t5_empty", out_valid, 0);

    // 6: async reset with 3 words buffered
    drive(1'b1, 4'h7, 2'd1, 2'd1); step();
    drive(1'b1, 4'h8, 2'd2, 2'd2); step();
    drive(1'b1, 4'h9, 2'd3, 2'd3); step();
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    chk("t6_pre_count", fifo_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_enc", encoded_count, 0);
    chk("t6_instr", out_instruction, 8'h00);
    step();
    rst = 1'b0;
    step();

    // encoded_count saturates at 255
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 4'h1, 2'd1, 2'd1);
      step();
    end
    drive(1'b0, 4'h0, 2'd0, 2'd0);
    step();
    out_ready = 1'b0;
    chk("sat_enc", encoded_count, 8'hFF);
    chk("sat_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
